// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in flight,
// and feeds decode through a stallable output register backed by a one-entry hold buffer.
package types;
  typedef logic [31:0] u32_t;
  typedef struct packed {
    u32_t ia_plus_4;
    u32_t ir;
  } id_params_t;
endpackage

module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [63:0] id_params
);
  import types::*;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e     state_q, state_d;
  u32_t       pc_q, pc_d;
  logic       out_vld_q, out_vld_d;
  id_params_t out_q, out_d;
  logic       hold_vld_q, hold_vld_d;
  id_params_t hold_q, hold_d;

  logic       out_free, resp, gnt;
  id_params_t entry;
  logic       unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_addr[1:0];

  assign out_free = !out_vld_q || !id_stall;
  assign resp     = (state_q == S_WAIT) && imem_rvalid;
  assign gnt      = imem_req && imem_gnt;
  // pc_q has already advanced past the outstanding fetch, so it is that fetch's ia+4.
  assign entry    = '{ia_plus_4: pc_q, ir: imem_rdata};

  assign imem_addr = pc_q;
  assign id_valid  = out_vld_q;
  assign id_params = out_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (!redirect_valid && gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)   state_d = imem_rvalid ? S_REQ : S_DRAIN;
        else if (imem_rvalid) state_d = gnt ? S_WAIT : S_REQ;
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem_req = !rst && !redirect_valid && !hold_vld_q &&
               ((state_q == S_REQ) || (resp && out_free));
  end

  always_comb begin
    pc_d       = pc_q;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    if (redirect_valid) begin
      pc_d       = {redirect_addr[31:2], 2'b00};
      out_vld_d  = 1'b0;
      hold_vld_d = 1'b0;
    end else begin
      if (gnt) pc_d = pc_q + 32'd4;
      if (resp) begin
        if (out_free) begin
          out_vld_d = 1'b1;
          out_d     = entry;
        end else begin
          hold_vld_d = 1'b1;
          hold_d     = entry;
        end
      end else if (out_vld_q && !id_stall) begin
        if (hold_vld_q) begin
          out_d      = hold_q;
          hold_vld_d = 1'b0;
        end else begin
          out_vld_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table for streaming/stall, directed redirect/wrap/reset
// sequences, then random traffic checked against an in-order instruction stream model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, redirect_addr;
  logic        redirect_valid, id_stall, id_valid;
  logic [63:0] id_params;
  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .id_stall(id_stall), .id_valid(id_valid), .id_params(id_params)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [63:0] pk(input logic [31:0] a);
    logic [31:0] n;
    n = a + 32'd4;
    return {n, dat(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rs, input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdr, input logic [31:0] ra, input logic st);
    rst = rs; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect_valid = rdr; redirect_addr = ra; id_stall = st;
  endtask

  // One clock: drive inputs, check settled outputs on the falling edge, advance.
  task automatic cyc(input string tag, input logic rs, input logic g, input logic rv,
                     input logic [31:0] rd, input logic rdr, input logic [31:0] ra,
                     input logic st, input logic ereq, input logic [31:0] eaddr,
                     input logic evld, input logic chkp, input logic [63:0] ep);
    drv(rs, g, rv, rd, rdr, ra, st);
    @(negedge clk);
    chk({tag, ".req"}, imem_req, ereq);
    chk({tag, ".addr"}, imem_addr, eaddr);
    chk({tag, ".vld"}, id_valid, evld);
    if (chkp) chk({tag, ".params"}, id_params, ep);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic rs, g, rv; logic [31:0] rd; logic st;
    logic ereq; logic [31:0] eaddr; logic evld; logic chkp; logic [63:0] ep;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic rs, input logic g, input logic rv, input logic [31:0] rd,
                              input logic st, input logic ereq, input logic [31:0] eaddr,
                              input logic evld, input logic chkp, input logic [63:0] ep);
    vec_t v;
    v.rs = rs; v.g = g; v.rv = rv; v.rd = rd; v.st = st;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.chkp = chkp; v.ep = ep;
    return v;
  endfunction

  logic [31:0] exp_a, maddr, ra;
  logic        pend, rv, g, st, rdr, prev_hold;
  logic [63:0] prev_p;
  int          cnt, ncons;

  initial begin
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;

    // streaming, stall for three cycles, release
    tbl.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h100, 0, 1, 64'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 1, 32'h100, 0, 0, 64'h0));
    tbl.push_back(mk(0, 1, 1, dat(32'h100),  0, 1, 32'h104, 0, 0, 64'h0));
    tbl.push_back(mk(0, 1, 1, dat(32'h104),  0, 1, 32'h108, 1, 1, pk(32'h100)));
    tbl.push_back(mk(0, 1, 1, dat(32'h108),  0, 1, 32'h10C, 1, 1, pk(32'h104)));
    tbl.push_back(mk(0, 1, 1, dat(32'h10C),  1, 0, 32'h110, 1, 1, pk(32'h108)));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h110, 1, 1, pk(32'h108)));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h110, 1, 1, pk(32'h108)));
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h110, 1, 1, pk(32'h108)));
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 1, 32'h110, 1, 1, pk(32'h10C)));
    tbl.push_back(mk(0, 1, 1, dat(32'h110),  0, 1, 32'h114, 0, 0, 64'h0));
    tbl.push_back(mk(0, 1, 1, dat(32'h114),  0, 1, 32'h118, 1, 1, pk(32'h110)));
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("tbl%0d", i), tbl[i].rs, tbl[i].g, tbl[i].rv, tbl[i].rd, 1'b0, 32'h0,
          tbl[i].st, tbl[i].ereq, tbl[i].eaddr, tbl[i].evld, tbl[i].chkp, tbl[i].ep);

    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // redirect while a 3-cycle fetch is in flight
    cyc("ra0", 0, 0, 0, 32'h0,        1, 32'h200, 0, 0, 32'h100, 0, 0, 64'h0);
    cyc("ra1", 0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 32'h200, 0, 0, 64'h0);
    cyc("ra2", 0, 0, 0, 32'h0,        1, 32'h403, 0, 0, 32'h204, 0, 0, 64'h0);
    cyc("ra3", 0, 1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h400, 0, 0, 64'h0);
    cyc("ra4", 0, 1, 1, dat(32'h200), 0, 32'h0,   0, 0, 32'h400, 0, 0, 64'h0);
    cyc("ra5", 0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 32'h400, 0, 0, 64'h0);
    cyc("ra6", 0, 0, 1, dat(32'h400), 0, 32'h0,   0, 1, 32'h404, 0, 0, 64'h0);
    // fill output and hold under stall, then redirect with a stray rvalid
    cyc("rb0", 0, 1, 0, 32'h0,        0, 32'h0,   1, 1, 32'h404, 1, 1, pk(32'h400));
    cyc("rb1", 0, 1, 1, dat(32'h404), 0, 32'h0,   1, 0, 32'h408, 1, 1, pk(32'h400));
    cyc("rb2", 0, 1, 0, 32'h0,        0, 32'h0,   1, 0, 32'h408, 1, 1, pk(32'h400));
    cyc("rb3", 0, 1, 1, 32'hDEAD_BEEF,1, 32'h600, 1, 0, 32'h408, 1, 1, pk(32'h400));
    cyc("rb4", 0, 0, 0, 32'h0,        0, 32'h0,   1, 1, 32'h600, 0, 0, 64'h0);
    // address wrap at the top of memory
    cyc("rc0", 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0, 32'h600, 0, 0, 64'h0);
    cyc("rc1", 0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 32'hFFFF_FFFC, 0, 0, 64'h0);
    cyc("rc2", 0, 0, 1, dat(32'hFFFF_FFFC), 0, 32'h0, 0, 1, 32'h0, 0, 0, 64'h0);
    cyc("rc3", 0, 1, 0, 32'h0,        0, 32'h0,   0, 1, 32'h0, 1, 1, pk(32'hFFFF_FFFC));
    // reset with a fetch outstanding; the late response must vanish
    cyc("rd0", 1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h4,   0, 0, 64'h0);
    cyc("rd1", 0, 0, 1, dat(32'h0),   0, 32'h0,   0, 1, 32'h100, 0, 1, 64'h0);
    cyc("rd2", 0, 0, 0, 32'h0,        0, 32'h0,   0, 1, 32'h100, 0, 1, 64'h0);

    // random traffic against the program-order stream model
    drv(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    exp_a = 32'h100; pend = 1'b0; cnt = 0; maddr = 32'h0; ncons = 0;
    prev_hold = 1'b0; prev_p = 64'h0;
    for (int c = 0; c < 4000; c++) begin
      rv  = pend && (cnt == 0);
      g   = ($urandom % 4) != 0;
      st  = ($urandom % 3) == 0;
      rdr = ($urandom % 25) == 0;
      ra  = $urandom;
      drv(1'b0, g, rv, rv ? dat(maddr) : $urandom, rdr, ra, st);
      @(negedge clk);
      if (prev_hold) begin
        chk("stall_vld", id_valid, 1'b1);
        chk("stall_params", id_params, prev_p);
      end
      chk("addr_align", imem_addr[1:0], 2'b00);
      if (imem_req && g) chk("one_outstanding", pend && !rv, 1'b0);
      if (id_valid && !st && !rdr) begin
        chk("stream", id_params, pk(exp_a));
        exp_a = exp_a + 32'd4;
        ncons++;
      end
      if (rdr) exp_a = {ra[31:2], 2'b00};
      prev_hold = id_valid && st && !rdr;
      prev_p    = id_params;
      if (rv) pend = 1'b0;
      else if (pend) cnt--;
      if (imem_req && g) begin
        pend  = 1'b1;
        cnt   = $urandom_range(2, 0);
        maddr = imem_addr;
      end
      @(posedge clk); #1;
    end
    chk("progress", ncons > 300, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch (IF) stage of the five-stage core. It owns the program counter and issues word fetches to instruction memory with at most one request outstanding. Returned instructions are packed into a `types::id_params_t` (`ia_plus_4`, `ir`) and handed to the decode stage through a valid/stall interface. Redirects from execute are absorbed, and stale in-flight responses are discarded.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word address of request (`u32_t`, bits [1:0] always 0).
- `imem_gnt`  in  1  request accepted this cycle when `imem_req && imem_gnt`.
- `imem_rvalid`  in  1  response valid; earliest one cycle after grant.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `redirect_valid`  in  1  control-flow change from EX.
- `redirect_addr`  in  32  new fetch address; bits [1:0] ignored (forced 0).
- `id_stall`  in  1  decode cannot accept; output must hold.
- `id_valid`  out  1  `id_params` carries a valid instruction.
- `id_params`  out  `$bits(id_params_t)` (64)  {`ia_plus_4`, `ir`} to decode.

## Operation
- Registers:
  - `pc`: next address to request.
  - State: `REQ` (may issue), `WAIT` (one outstanding, keep), `DRAIN` (one outstanding, discard).
  - Output register: `id_valid`, `id_params`.
  - One-entry hold buffer: `hold_valid`, `hold_params`.
- `imem_addr = pc`.
- Issue condition: `imem_req = !rst && !redirect_valid && !hold_valid && (state==REQ || (state==WAIT && imem_rvalid && (!id_valid || !id_stall)))`. This is combinational.
- On grant: `pc <= pc + 4` (mod 2^32, wraps FFFF_FFFC→0000_0000) and `state <= WAIT`. The new `pc` equals the `ia_plus_4` of the outstanding fetch.
- Response in `WAIT` with entry = {`pc`, `imem_rdata`}:
  - Output free (`!id_valid || !id_stall`): the entry loads the output register.
  - Otherwise: the entry loads the hold buffer.
  - `state <= REQ`, or stays `WAIT` if a grant occurs in the same cycle.
- Consumption (`id_valid && !id_stall`) with no new response:
  - Hold full: hold moves to output and hold clears.
  - Hold empty: `id_valid <= 0`.
- `rvalid` with no outstanding request (`REQ` state): protocol violation. Ignore it; nothing changes.
- Redirect (highest priority over all of the above):
  - `pc <= {redirect_addr[31:2], 2'b00}`; `id_valid <= 0`; `hold_valid <= 0`; no request is issued this cycle.
  - State `WAIT` with no `rvalid` this cycle: `state <= DRAIN`.
  - State `WAIT` with `rvalid` this cycle: the response is dropped; `state <= REQ`.
  - State `DRAIN`: stays `DRAIN` unless `rvalid` arrives this cycle.
  - State `REQ`: `state <= REQ`.
- `DRAIN`:
  - `imem_req = 0`.
  - The next `rvalid` is discarded; `state <= REQ`.
  - Further redirects while in `DRAIN` only update `pc`.
- `id_stall` with `id_valid=0` has no effect.

## Timing
- Reset values: `pc = RESET_VECTOR`, state `REQ`, `id_valid = 0`, `id_params = 0`, `hold_valid = 0`, `hold_params = 0`, `imem_req = 0` while `rst` is high.
- First request: `imem_req = 1` in the first cycle after `rst` falls.
- Latency: grant in cycle N, `rvalid` in N+1 → `id_valid = 1` in N+2.
- Throughput: with a 1-cycle memory and no stall, one instruction per cycle (re-issue in the `rvalid` cycle).
- Stall: output and hold are frozen while `id_stall = 1`. At most two instructions are buffered; fetch stops while `hold_valid = 1`.
- Redirect in cycle N: `imem_addr = redirect target` from N+1. The earliest request is in N+1 (`REQ`) or in the cycle after the drained response.
- Reset mid-operation: all state returns to reset values on the next edge. Any response arriving after reset release without a post-reset grant is ignored.

## Test plan
- Reset, `RESET_VECTOR=0x100`, always-grant, 1-cycle memory returning addr^0xA5A5_0000, no stall → `imem_addr` = 0x100, 0x104, 0x108 on consecutive cycles; `id_params` = {0x104, 0xA5A5_0100}, then {0x108, …} every cycle.
- Assert `id_stall` for 3 cycles while streaming → `id_params` held; `imem_req` drops once `hold_valid=1`; on release, instructions resume in order with none lost or duplicated.
- Grant at 0x200, redirect to 0x403 before `rvalid` (3-cycle memory) → `id_valid` stays 0; the response for 0x200 is discarded; next request `imem_addr = 0x400`; first output {0x404, data(0x400)}.
- Redirect in the same cycle as `rvalid` with `id_stall=1` and hold full → output and hold cleared; `imem_req = 0` that cycle; next request to the redirect target.
- `pc` at 0xFFFF_FFFC → `ia_plus_4 = 0x0000_0000`; next `imem_addr = 0x0`.
- Assert `rst` while in `WAIT` → next cycle `id_valid=0`, `imem_addr = RESET_VECTOR`; a late `rvalid` before any new grant produces no output.
